// File: rtl/c_pkg.sv
// Shared definitions for the coefficient round-and-stream slice.
// Holds the memory geometry, the polynomial parameters and the FSM
// state encoding used by c_round_stream.
package c_pkg;

    localparam int RAM_WIDTH     = 12;
    localparam int RAM_ADDR_BITS = 10;
    localparam int N             = 757;
    localparam int Q             = 4091;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/c_round3.sv
// Combinational sntrup Round of one residue.
// Centres x from [0,MOD) into [-(MOD-1)/2, (MOD-1)/2] and moves it to the
// nearest multiple of 3.
// Ports:
//   x  in   W      residue in [0,MOD)
//   y  out  OUT_W  rounded value, two's complement
module c_round3
    import c_pkg::*;
#(
    parameter int W     = RAM_WIDTH,
    parameter int MOD   = Q,
    parameter int OUT_W = W + 1
) (
    input  logic [W-1:0]     x,
    output logic [OUT_W-1:0] y
);

    localparam int HALF = (MOD - 1) / 2;
    // Smallest multiple of 3 that is >= HALF. Adding it to the centred value
    // makes it non-negative without changing its residue mod 3, so a plain
    // unsigned modulo yields the non-negative residue for negative values too.
    localparam int BIAS = ((HALF + 2) / 3) * 3;

    localparam logic [OUT_W-1:0] HALF_V = OUT_W'(HALF);
    localparam logic [OUT_W-1:0] MOD_V  = OUT_W'(MOD);
    localparam logic [OUT_W-1:0] BIAS_V = OUT_W'(BIAS);
    localparam logic [OUT_W-1:0] ONE    = OUT_W'(1);
    localparam logic [OUT_W-1:0] THREE  = OUT_W'(3);

    logic [OUT_W-1:0] x_ext;
    logic [OUT_W-1:0] v;
    logic [OUT_W-1:0] u;
    logic [OUT_W-1:0] rem;

    // All arithmetic is done on OUT_W-bit patterns; wrap-around gives the
    // correct two's complement result because |v| <= HALF fits in OUT_W bits.
    always_comb begin
        x_ext = {1'b0, x};
        v     = (x_ext > HALF_V) ? (x_ext - MOD_V) : x_ext;
        u     = v + BIAS_V;
        rem   = u % THREE;
        if (rem == '0) begin
            y = v;
        end else if (rem == ONE) begin
            y = v - ONE;
        end else begin
            y = v + ONE;
        end
    end

endmodule

// File: rtl/c_round_stream.sv
// Reads N coefficients from the coefficient RAM, rounds each to a multiple
// of 3 (centred) and streams them out over a valid/ready interface.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                one-cycle run request (accepted in IDLE or DONE)
//   busy, done           run in progress / one-cycle completion pulse
//   rd_addr, rd_data     asynchronous-read RAM port
//   out_data, out_valid, out_ready, out_last   output stream
module c_round_stream #(
    parameter int RAM_WIDTH     = c_pkg::RAM_WIDTH,
    parameter int RAM_ADDR_BITS = c_pkg::RAM_ADDR_BITS,
    parameter int N             = c_pkg::N,
    parameter int Q             = c_pkg::Q,
    parameter int OUT_W         = RAM_WIDTH + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [RAM_ADDR_BITS-1:0] rd_addr,
    input  logic [RAM_WIDTH-1:0]     rd_data,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    import c_pkg::*;

    localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(N - 1);
    localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE  = RAM_ADDR_BITS'(1);

    state_t                   state;
    state_t                   state_nxt;
    logic [RAM_ADDR_BITS-1:0] cnt;
    logic                     s1_valid;
    logic                     s1_last;
    logic [RAM_WIDTH-1:0]     s1_data;
    logic [OUT_W-1:0]         rounded;
    logic                     adv;
    logic                     at_last;
    logic                     start_accept;

    // The whole pipeline moves only when the output register can be emptied.
    assign adv          = !out_valid || out_ready;
    assign at_last      = (cnt == LAST_ADDR);
    assign rd_addr      = cnt;
    assign start_accept = start && ((state == IDLE) || (state == DONE));

    c_round3 #(
        .W     (RAM_WIDTH),
        .MOD   (Q),
        .OUT_W (OUT_W)
    ) u_round3 (
        .x (s1_data),
        .y (rounded)
    );

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (adv && at_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (out_valid && out_ready && out_last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                // A start arriving with done chains straight into the next run.
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state <= state_nxt;

            // The counter saturates at N-1 so rd_addr parks there while draining.
            if (start_accept) begin
                cnt <= '0;
            end else if ((state == RUN) && adv && !at_last) begin
                cnt <= cnt + ADDR_ONE;
            end

            if (adv) begin
                s1_valid  <= (state == RUN);
                s1_last   <= (state == RUN) && at_last;
                s1_data   <= rd_data;
                out_valid <= s1_valid;
                out_last  <= s1_last;
                out_data  <= rounded;
            end
        end
    end

endmodule
